// File: rtl/mtr_drv_pkg.sv
// Shared definitions for the dual-channel motor PWM driver.
//   PWM_W      : width of the PWM counter, duty and speed words (period 2**PWM_W clocks)
//   ZERO_DUTY  : duty value that yields zero average drive (50%)
//   spd_t      : signed two's-complement speed command
package mtr_drv_pkg;

   localparam int unsigned PWM_W = 11;

   localparam logic [PWM_W-1:0] ZERO_DUTY = 11'h400;

   typedef logic signed [PWM_W-1:0] spd_t;

endpackage

// File: rtl/pwm11.sv
// Single-channel complementary PWM generator.
//   clk, rst_n : clock, synchronous active-low reset
//   duty_i     : unsigned duty, sampled only on the last count of a period
//   pwm1_o     : forward leg, high while cnt < duty (registered)
//   pwm2_o     : reverse leg, complement of pwm1_o out of reset (registered)
module pwm11
   import mtr_drv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PWM_W-1:0] duty_i,
   output logic             pwm1_o,
   output logic             pwm2_o
);

   localparam logic [PWM_W-1:0] CNT_MAX = '1;

   logic [PWM_W-1:0] cnt_q,  cnt_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic             pwm1_q, pwm1_d;
   logic             pwm2_q, pwm2_d;

   // Next-state: free-running counter, duty latched at period end, compare.
   always_comb begin
      cnt_d  = cnt_q + PWM_W'(1);
      duty_d = duty_q;
      // Loading on the last count makes a new duty start exactly at cnt 0.
      if (cnt_q == CNT_MAX) begin
         duty_d = duty_i;
      end
      pwm1_d = (cnt_q < duty_q);
      pwm2_d = ~(cnt_q < duty_q);
   end

   // State registers; reset turns both bridge legs off.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         duty_q <= ZERO_DUTY;
         pwm1_q <= 1'b0;
         pwm2_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pwm1_q <= pwm1_d;
         pwm2_q <= pwm2_d;
      end
   end

   assign pwm1_o = pwm1_q;
   assign pwm2_o = pwm2_q;

endmodule

// File: rtl/mtr_drv.sv
// Dual-channel motor driver: signed speed -> complementary H-bridge PWM pair.
//   clk, rst_n         : clock, synchronous active-low reset
//   lft_spd, rght_spd  : signed speed commands (-1024..+1023)
//   lftPWM1/lftPWM2    : left forward/reverse legs (registered)
//   rghtPWM1/rghtPWM2  : right forward/reverse legs (registered)
module mtr_drv
   import mtr_drv_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [PWM_W-1:0] lft_spd,
   input  logic signed [PWM_W-1:0] rght_spd,
   output logic                    lftPWM1,
   output logic                    lftPWM2,
   output logic                    rghtPWM1,
   output logic                    rghtPWM2
);

   logic [PWM_W-1:0] lft_duty_c;
   logic [PWM_W-1:0] rght_duty_c;

   // Offset by half scale (mod 2**PWM_W) so zero speed is 50% duty.
   assign lft_duty_c  = $unsigned(lft_spd)  + ZERO_DUTY;
   assign rght_duty_c = $unsigned(rght_spd) + ZERO_DUTY;

   // Identical reset keeps the two per-channel counters in lockstep.
   pwm11 u_lft (
      .clk    (clk),
      .rst_n  (rst_n),
      .duty_i (lft_duty_c),
      .pwm1_o (lftPWM1),
      .pwm2_o (lftPWM2)
   );

   pwm11 u_rght (
      .clk    (clk),
      .rst_n  (rst_n),
      .duty_i (rght_duty_c),
      .pwm1_o (rghtPWM1),
      .pwm2_o (rghtPWM2)
   );

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: per-period duty, shape and complement checks.
module tb_mtr_drv;

   logic               clk;
   logic               rst_n;
   logic signed [10:0] lft_spd;
   logic signed [10:0] rght_spd;
   logic               lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;

   int n_chk  = 0;
   int n_pass = 0;
   int prev_l = 0;
   int prev_r = 0;

   mtr_drv u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .lftPWM1  (lftPWM1),
      .lftPWM2  (lftPWM2),
      .rghtPWM1 (rghtPWM1),
      .rghtPWM2 (rghtPWM2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Speed -> high clocks per period: shift signed range up by half scale.
   function automatic int map_duty(input int s);
      return (s + 1024) % 2048;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int l, input int r);
      lft_spd  = 11'(l);
      rght_spd = 11'(r);
   endtask

   task automatic check_off(input string tag);
      n_chk++;
      if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2} !== 4'b0000)
         $display("FAIL %s outputs: got %b%b%b%b want 0000", tag, lftPWM1, lftPWM2, rghtPWM1, rghtPWM2);
      else n_pass++;
      n_chk++;
      if (u_dut.u_lft.cnt_q !== 11'd0 || u_dut.u_rght.cnt_q !== 11'd0)
         $display("FAIL %s cnt: got %0d/%0d want 0", tag, u_dut.u_lft.cnt_q, u_dut.u_rght.cnt_q);
      else n_pass++;
   endtask

   // One full 2048-clock output period; optional left speed change at clock chg_at.
   task automatic run_period(input string tag, input int el, input int er,
                             input int chg_at, input int chg_l);
      int lh = 0, rh = 0, l2h = 0, r2h = 0, bad_pair = 0, lshape = 0, rshape = 0;
      for (int i = 0; i < 2048; i++) begin
         if (i == chg_at) lft_spd = 11'(chg_l);
         step();
         if (lftPWM1  === 1'b1) lh++;
         if (rghtPWM1 === 1'b1) rh++;
         if (lftPWM2  === 1'b1) l2h++;
         if (rghtPWM2 === 1'b1) r2h++;
         if (lftPWM1 === lftPWM2 || rghtPWM1 === rghtPWM2) bad_pair++;
         if (lftPWM1  !== 1'(i < el)) lshape++;
         if (rghtPWM1 !== 1'(i < er)) rshape++;
      end
      n_chk++;
      if (lh !== el) $display("FAIL %s lftPWM1 high: got %0d want %0d", tag, lh, el);
      else n_pass++;
      n_chk++;
      if (rh !== er) $display("FAIL %s rghtPWM1 high: got %0d want %0d", tag, rh, er);
      else n_pass++;
      n_chk++;
      if (l2h !== 2048 - el) $display("FAIL %s lftPWM2 high: got %0d want %0d", tag, l2h, 2048 - el);
      else n_pass++;
      n_chk++;
      if (r2h !== 2048 - er) $display("FAIL %s rghtPWM2 high: got %0d want %0d", tag, r2h, 2048 - er);
      else n_pass++;
      n_chk++;
      if (bad_pair !== 0) $display("FAIL %s non-complement clocks: got %0d want 0", tag, bad_pair);
      else n_pass++;
      n_chk++;
      if (lshape !== 0) $display("FAIL %s lft shape/alignment errors: got %0d want 0", tag, lshape);
      else n_pass++;
      n_chk++;
      if (rshape !== 0) $display("FAIL %s rght shape/alignment errors: got %0d want 0", tag, rshape);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0);
      repeat (3) step();
      check_off("reset_hold");
   endtask

   task automatic test_first_period();
      // Inputs already set before release must be ignored for one period.
      drive(-241, -253);
      rst_n = 1'b1;
      run_period("first_period", 1024, 1024, -1, 0);
      prev_l = -241;
      prev_r = -253;
   endtask

   task automatic test_fixed_speeds();
      run_period("fixed_a", map_duty(prev_l), map_duty(prev_r), -1, 0);
      run_period("fixed_b", map_duty(prev_l), map_duty(prev_r), -1, 0);
   endtask

   task automatic test_extremes();
      drive(-1024, 1023);
      run_period("extreme_pre", map_duty(prev_l), map_duty(prev_r), -1, 0);
      prev_l = -1024;
      prev_r = 1023;
      run_period("extreme_a", 0, 2047, -1, 0);
      drive(0, 0);
      run_period("extreme_b", 0, 2047, -1, 0);
      prev_l = 0;
      prev_r = 0;
   endtask

   task automatic test_mid_change();
      run_period("mid_pre", 1024, 1024, 500, 512);
      prev_l = 512;
      run_period("mid_post", 1536, 1024, -1, 0);
   endtask

   task automatic test_random();
      for (int p = 0; p < 4; p++) begin
         int nl = int'($urandom_range(2047, 0)) - 1024;
         int nr = int'($urandom_range(2047, 0)) - 1024;
         drive(nl, nr);
         run_period("random", map_duty(prev_l), map_duty(prev_r), -1, 0);
         prev_l = nl;
         prev_r = nr;
      end
   endtask

   task automatic test_reset_mid();
      drive(-241, prev_r);
      run_period("rmid_pre", map_duty(prev_l), map_duty(prev_r), -1, 0);
      prev_l = -241;
      // Into a 783-duty period, reset at count 1300.
      repeat (1300) step();
      rst_n = 1'b0;
      step();
      check_off("reset_mid_edge");
      repeat (2) step();
      check_off("reset_mid_hold");
      rst_n = 1'b1;
      run_period("rmid_first", 1024, 1024, -1, 0);
      run_period("rmid_second", map_duty(prev_l), map_duty(prev_r), -1, 0);
   endtask

   initial begin
      test_reset();
      test_first_period();
      test_fixed_speeds();
      test_extremes();
      test_mid_change();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
